// File: rtl/divide_core.sv
// divide_core: multi-cycle 32-bit signed divider (quotient only), non-restoring, one bit per clock.
// DIVIDE_EARLY_EXC_EN: report divide-by-zero one edge after the start instead of after 33.
module divide_core #(
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] data_result,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             clock,
    input  logic             ctrl_DIV,
    output logic             data_resultRDY,
    output logic             data_exception,
    input  logic             reset_n
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [5:0] counter;
    logic [WIDTH+1:0] rem, rem_sh, rem_nx;
    logic [WIDTH-1:0] quo, a_mag;
    logic [WIDTH:0] b_mag, b_in;
    logic neg, exc, start_exc, b_zero, early;
    always_comb begin
        a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_in = data_operandB[WIDTH-1] ? -{1'b1, data_operandB} : {1'b0, data_operandB};
        b_zero = data_operandB == '0;
        start_exc = b_zero | (data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && data_operandB == '1);
`ifdef DIVIDE_EARLY_EXC_EN
        early = b_zero;
`else
        early = 1'b0;
`endif
        // remainder is two bits wider than the operands so the shifted value never overflows
        rem_sh = {rem[WIDTH:0], quo[WIDTH-1]};
        rem_nx = rem[WIDTH+1] ? rem_sh + {1'b0, b_mag} : rem_sh - {1'b0, b_mag};
        state_nx = ctrl_DIV ? RUN : (state == RUN && counter == 6'd32) ? DONE : (state == RUN) ? RUN : IDLE;
        data_resultRDY = state == DONE;
        data_exception = state == DONE && exc;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            counter <= '0;
            rem <= '0;
            quo <= '0;
            b_mag <= '0;
            neg <= 1'b0;
            exc <= 1'b0;
            data_result <= '0;
        end else begin
            state <= state_nx;
            if (ctrl_DIV) begin
                rem <= '0;
                quo <= a_mag;
                b_mag <= b_in;
                neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                exc <= start_exc;
                counter <= early ? 6'd32 : 6'd0;
            end else if (state == RUN) begin
                if (counter == 6'd32)
                    data_result <= exc ? '0 : neg ? -quo : quo;
                else begin
                    rem <= rem_nx;
                    quo <= {quo[WIDTH-2:0], ~rem_nx[WIDTH+1]};
                    counter <= counter + 6'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_divide_core.sv
// tb_divide_core: scoreboard bench for divide_core; expectations queued at start, checked on each RDY pulse.
module tb_divide_core;
    logic [31:0] data_result, data_operandA, data_operandB;
    logic clock = 1'b0, ctrl_DIV = 1'b0, reset_n = 1'b0;
    logic data_resultRDY, data_exception;
    int tests = 0, fails = 0, cyc = 0;
`ifdef DIVIDE_EARLY_EXC_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif
    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;
    exp_t q[$];
    exp_t e;

    divide_core dut (
        .data_result(data_result),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .clock(clock),
        .ctrl_DIV(ctrl_DIV),
        .data_resultRDY(data_resultRDY),
        .data_exception(data_exception),
        .reset_n(reset_n)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && data_resultRDY) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rdy at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                check("result", data_result, e.res);
                check("exception", {31'b0, data_exception}, {31'b0, e.exc});
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_empty();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clock);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL rdy_timeout: pending %0d expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input logic x, input int lat);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        q.push_back('{r, x, cyc + 1 + lat});
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_empty();
    endtask

    initial begin
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset_result", data_result, 32'h0);
        check("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
        check("reset_exc", {31'b0, data_exception}, 32'h0);
        reset_n = 1'b1;
        run(32'h80000000, 32'h80000000, 32'h1, 1'b0, 33);
        run(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
        run(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33);
        run(32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 1'b0, 33);
        run(32'd100, 32'd7, 32'd14, 1'b0, 33);
        run(32'd100, 32'd0, 32'd0, 1'b1, ZLAT);
        run(32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, 33);
        run(32'h80000000, 32'd2, 32'hC0000000, 1'b0, 33);
        run(32'h80000000, 32'd1, 32'h80000000, 1'b0, 33);
        run(32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 33);
        run(32'h7FFFFFFF, 32'd2, 32'h3FFFFFFF, 1'b0, 33);
        run(32'd1, 32'h7FFFFFFF, 32'd0, 1'b0, 33);
        // restart mid-run: only the second division may report
        @(negedge clock);
        data_operandA = 32'd5;
        data_operandB = 32'd1;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (10) @(negedge clock);
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        ctrl_DIV = 1'b1;
        q.push_back('{32'd3, 1'b0, cyc + 34});
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_empty();
        // reset mid-run aborts and clears everything
        @(negedge clock);
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("midreset_result", data_result, 32'h0);
        check("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
        check("midreset_exc", {31'b0, data_exception}, 32'h0);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        run(32'd100, 32'd7, 32'd14, 1'b0, 33);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
